instr_fetch: RTL and testbench

//   Instruction fetch stage placed directly upstream of basicMemory (instruction port).
//   - Owns the program counter and issues reads to the memory.
//   - Captures the registered read data and presents one instruction at a time to decode

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_if.sv | 47 ++++
 rtl/instr_fetch.sv | 83 ++++++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch stage
// FSM state encoding, default widths and the NOP encoding used by decode.
package instr_fetch_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 32;

  // 2'd3 is never entered; the FSM recovers from it to S_ISSUE.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_RESP  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory, redirect and decode handshake bundle of the fetch stage
// master = fetch stage, slave = memory/execute/decode environment.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              fetch_en;

  logic              mem_ce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    input  fetch_en,
    output mem_ce, mem_wre, mem_ad, mem_din,
    input  mem_dout,
    input  redirect_valid, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr, instr_pc, fetch_cnt
  );

  modport slave (
    output fetch_en,
    input  mem_ce, mem_wre, mem_ad, mem_din,
    output mem_dout,
    output redirect_valid, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_pc, fetch_cnt
  );

endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and 3-cycle fetch FSM feeding decode over valid/ready
// Issues a read, captures the registered memory data, holds it until decode accepts.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc_d;
  logic              instr_valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic              accept_d;

  // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap of the PC.
  assign pc_inc_d = pc_q + ADDR_W'(PC_STEP);
  assign accept_d = (state_q == S_HOLD) && bus.instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_ISSUE;
      pc_q          <= ADDR_W'(RESET_PC);
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_cnt_q   <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins everywhere; an instruction accepted this same cycle still counts.
      state_q       <= S_ISSUE;
      pc_q          <= bus.redirect_pc;
      instr_valid_q <= 1'b0;
      if (accept_d) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (bus.fetch_en) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          instr_q       <= bus.mem_dout;
          instr_pc_q    <= pc_q;
          instr_valid_q <= 1'b1;
          state_q       <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_inc_d;
            fetch_cnt_q   <= fetch_cnt_q + CNT_W'(1);
            state_q       <= S_ISSUE;
          end
        end
        default: begin
          instr_valid_q <= 1'b0;
          state_q       <= S_ISSUE;
        end
      endcase
    end
  end

  assign bus.mem_ce      = (state_q == S_ISSUE) || (state_q == S_RESP);
  assign bus.mem_wre     = 1'b0;
  assign bus.mem_ad      = pc_q;
  assign bus.mem_din     = '0;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch with a registered memory model
// Per-cycle vector table plus hand-written reset and fetch-enable sequences.
module tb_instr_fetch;

  logic clk;
  logic rst;

  instr_fetch_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  instr_fetch #(.ADDR_W(8), .DATA_W(32), .RESET_PC(0), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered, word-indexed instruction memory: dout follows mem[ad] one edge later.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_ce && !bus.mem_wre) begin
      bus.mem_dout <= mem[bus.mem_ad[7:2]];
    end
  end

  typedef struct {
    logic        fen;
    logic        rdy;
    logic        rv;
    logic [7:0]  rpc;
    logic        ev;
    logic [31:0] ei;
    logic [7:0]  eipc;
    logic [7:0]  ead;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input logic fen, input logic rdy, input logic rv, input logic [7:0] rpc,
                     input logic ev, input logic [31:0] ei, input logic [7:0] eipc,
                     input logic [7:0] ead, input logic [31:0] ecnt);
    vec_t v;
    v.fen = fen; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ei = ei; v.eipc = eipc; v.ead = ead; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int idx, input vec_t v);
    logic ok;
    ok = (bus.instr_valid === v.ev) && (bus.mem_ad === v.ead) && (bus.fetch_cnt === v.ecnt)
         && (bus.mem_wre === 1'b0) && (bus.mem_din === 32'h0);
    if (v.ev) ok = ok && (bus.instr === v.ei) && (bus.instr_pc === v.eipc);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got valid=%b instr=%h pc=%h ad=%h cnt=%0d expected valid=%b instr=%h pc=%h ad=%h cnt=%0d",
               idx, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_ad, bus.fetch_cnt,
               v.ev, v.ei, v.eipc, v.ead, v.ecnt);
    end
  endtask

  localparam logic [31:0] I0  = 32'h0280_2483;
  localparam logic [31:0] I4  = 32'h02C0_2503;
  localparam logic [31:0] I8  = 32'h00A4_85B3;
  localparam logic [31:0] I12 = 32'h40B5_0633;
  localparam logic [31:0] I252 = 32'hC0DE_003F;

  initial begin
    int cyc;
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = I0; mem[1] = I4; mem[2] = I8; mem[3] = I12;

    bus.fetch_en       = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.instr_valid), 32'h0);
    chk("reset_instr", bus.instr, 32'h0);
    chk("reset_instr_pc", 32'(bus.instr_pc), 32'h0);
    chk("reset_cnt", bus.fetch_cnt, 32'h0);
    chk("reset_ad", 32'(bus.mem_ad), 32'h0);
    chk("reset_ce", 32'(bus.mem_ce), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    //   fen rdy rv rpc    ev  instr eipc  ad     cnt
    // steady stream, ready high
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd0,   0);
    add(1, 1, 0, 8'd0,   1, I0,   8'd0,   8'd0,   0);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd4,   1);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd4,   1);
    add(1, 1, 0, 8'd0,   1, I4,   8'd4,   8'd4,   1);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd8,   2);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd8,   2);
    add(1, 0, 0, 8'd0,   1, I8,   8'd8,   8'd8,   2);
    // back-pressure for 5 cycles, then release
    for (int i = 0; i < 5; i++) add(1, 0, 0, 8'd0, 1, I8, 8'd8, 8'd8, 2);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd12,  3);
    // redirect during S_RESP of pc=12 drops that read
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd12,  3);
    add(1, 1, 1, 8'd0,   0, 0,    8'd0,   8'd0,   3);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd0,   3);
    add(1, 1, 0, 8'd0,   1, I0,   8'd0,   8'd0,   3);
    // redirect together with accept in S_HOLD
    add(1, 1, 1, 8'd8,   0, 0,    8'd0,   8'd8,   4);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd8,   4);
    add(1, 0, 0, 8'd0,   1, I8,   8'd8,   8'd8,   4);
    // redirect without accept to 252, then PC wrap on accept
    add(1, 0, 1, 8'd252, 0, 0,    8'd0,   8'd252, 4);
    add(1, 0, 0, 8'd0,   0, 0,    8'd0,   8'd252, 4);
    add(1, 0, 0, 8'd0,   1, I252, 8'd252, 8'd252, 4);
    add(0, 1, 0, 8'd0,   0, 0,    8'd0,   8'd0,   5);
    // fetch_en low holds S_ISSUE; low outside S_ISSUE has no effect
    add(0, 1, 0, 8'd0,   0, 0,    8'd0,   8'd0,   5);
    add(1, 1, 0, 8'd0,   0, 0,    8'd0,   8'd0,   5);
    add(0, 1, 0, 8'd0,   1, I0,   8'd0,   8'd0,   5);
    add(0, 1, 0, 8'd0,   0, 0,    8'd0,   8'd4,   6);
    add(0, 1, 0, 8'd0,   0, 0,    8'd0,   8'd4,   6);
    // redirect in S_ISSUE
    add(1, 1, 1, 8'd12,  0, 0,    8'd0,   8'd12,  6);
    add(1, 0, 0, 8'd0,   0, 0,    8'd0,   8'd12,  6);
    add(1, 0, 0, 8'd0,   1, I12,  8'd12,  8'd12,  6);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.fetch_en       = vecs[i].fen;
      bus.instr_ready    = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk_vec(i, vecs[i]);
    end

    // asynchronous reset in S_HOLD takes effect before the next edge
    bus.redirect_valid = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.instr_ready    = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("async_rst_ad", 32'(bus.mem_ad), 32'h0);
    chk("async_rst_cnt", bus.fetch_cnt, 32'h0);
    chk("async_rst_instr_pc", 32'(bus.instr_pc), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("fen0_ad", 32'(bus.mem_ad), 32'h0);
      chk("fen0_valid", 32'(bus.instr_valid), 32'h0);
      chk("fen0_ce", 32'(bus.mem_ce), 32'h1);
    end

    bus.fetch_en = 1'b1;
    cyc = 0;
    while (bus.instr_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("restart_latency", 32'(cyc), 32'd2);
    chk("restart_instr", bus.instr, I0);
    chk("restart_cnt", bus.fetch_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
